// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared defaults and response FSM encoding for the SPI request arbiter
package spi_arb_pkg;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_TAG_DEPTH = 8;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_POP  = 2'd1,
    R_DATA = 2'd2
  } rsp_state_t;
endpackage

// File: rtl/spi_tag_fifo.sv
// rtl/spi_tag_fifo.sv - synchronous FIFO of requester tags awaiting an SPI response
module spi_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic do_push;
  logic do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/spi_req_arbiter.sv
// rtl/spi_req_arbiter.sv - round-robin arbiter sharing one SPI FIFO pair, with tagged response routing
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TAG_DEPTH = DEF_TAG_DEPTH,
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W    = $clog2(TAG_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      wr_fifo_wrreq,
  output logic [DATA_W-1:0]         wr_fifo_data,
  input  logic                      wr_fifo_full,
  output logic                      rd_fifo_rdreq,
  input  logic [DATA_W-1:0]         rd_fifo_q,
  input  logic                      rd_fifo_empty,
  output logic [CNT_W-1:0]          outstanding,
  output logic                      err_orphan,
  input  logic                      err_clr
);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic             accept;
  logic             tag_full;
  logic             tag_empty;
  logic             tag_pop;
  logic [IDX_W-1:0] tag_head;
  rsp_state_t       state;

  function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] v,
                                            input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] w;
    logic             found;
    int               j;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && v[j]) begin
        found = 1'b1;
        w     = IDX_W'(j);
      end
    end
    return w;
  endfunction

  // Reset gates the combinational handshake so nothing is accepted while it is held.
  assign winner        = pick(req_valid, rr_ptr);
  assign accept        = !reset && (|req_valid) && !wr_fifo_full && !tag_full;
  assign req_ready     = accept ? (ONE << winner) : '0;
  assign wr_fifo_wrreq = accept;
  assign wr_fifo_data  = req_data[winner*DATA_W +: DATA_W];
  assign tag_pop       = (state == R_DATA) && !tag_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept) begin
      if (req_lock[winner])                    rr_ptr <= winner;
      else if (winner == IDX_W'(NUM_REQ - 1))  rr_ptr <= '0;
      else                                     rr_ptr <= winner + 1'b1;
    end
  end

  spi_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (IDX_W)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (winner),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (outstanding)
  );

  // A clear and a new orphan in the same cycle: the later set assignment wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= R_IDLE;
      rd_fifo_rdreq <= 1'b0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      err_orphan    <= 1'b0;
    end else begin
      rd_fifo_rdreq <= 1'b0;
      rsp_valid     <= '0;
      if (err_clr) err_orphan <= 1'b0;
      case (state)
        R_IDLE: begin
          if (!rd_fifo_empty) begin
            state         <= R_POP;
            rd_fifo_rdreq <= 1'b1;
          end
        end
        R_POP: state <= R_DATA;
        R_DATA: begin
          state <= R_IDLE;
          if (!tag_empty) begin
            rsp_data  <= rd_fifo_q;
            rsp_valid <= ONE << tag_head;
          end else begin
            err_orphan <= 1'b1;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end
endmodule
